// File: rtl/control_recorrido_if.sv
// Handshake and result bundle for the MSB-first slice comparator.
// master: operand producer (drives start/abort/wordA/wordB, observes results)
// slave : control_recorrido (samples requests, drives busy/done/result flags/pasos)
interface control_recorrido_if #(
  parameter int N = 8,
  parameter int K = 4
);
  localparam int PW = $clog2(K + 1);

  logic           start;
  logic           abort;
  logic [N*K-1:0] wordA;
  logic [N*K-1:0] wordB;
  logic           busy;
  logic           done;
  logic           mayor;
  logic           menor;
  logic           igual;
  logic [PW-1:0]  pasos;

  modport master (
    output start, abort, wordA, wordB,
    input  busy, done, mayor, menor, igual, pasos
  );

  modport slave (
    input  start, abort, wordA, wordB,
    output busy, done, mayor, menor, igual, pasos
  );
endinterface

// File: rtl/control_recorrido.sv
// control_recorrido: sequential unsigned magnitude compare of two N*K-bit
// operands, one N-bit slice per clock, most significant slice first. Stops at
// the first differing slice and reports mayor/menor/igual plus the number of
// slices examined (pasos). All outputs are registered.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (returns to IDLE, clears outputs)
//   bus   - control_recorrido_if.slave: start/abort/wordA/wordB in,
//           busy/done/mayor/menor/igual/pasos out
module control_recorrido #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  control_recorrido_if.slave  bus
);
  localparam int PW = $clog2(K + 1);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [PW-1:0]  steps_q, steps_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           mayor_q, mayor_d;
  logic           menor_q, menor_d;
  logic           igual_q, igual_d;
  logic [PW-1:0]  pasos_q, pasos_d;

  // Operand copies are pure data: loaded on an accepted start, never reset.
  logic [N*K-1:0] a_q, b_q;
  logic           load;
  logic [N-1:0]   slice_a, slice_b;

  assign load = (state_q == IDLE) && bus.start;

  // Slice mux built from constant part-selects to keep index arithmetic static.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < K; i++) begin
      if (IW'(i) == idx_q) begin
        slice_a = a_q[i*N +: N];
        slice_b = b_q[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    steps_d = steps_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mayor_d = mayor_q;
    menor_d = menor_q;
    igual_d = igual_q;
    pasos_d = pasos_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          idx_d   = IW'(K - 1);
          steps_d = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        // Abort wins even if this slice would have finished the compare;
        // results from the previous compare are left untouched.
        if (bus.abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          steps_d = steps_q + 1'b1;
          if (slice_a != slice_b) begin
            mayor_d = (slice_a > slice_b);
            menor_d = (slice_a < slice_b);
            igual_d = 1'b0;
            pasos_d = steps_q + 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (idx_q == '0) begin
            mayor_d = 1'b0;
            menor_d = 1'b0;
            igual_d = 1'b1;
            pasos_d = PW'(K);
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      steps_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mayor_q <= 1'b0;
      menor_q <= 1'b0;
      igual_q <= 1'b0;
      pasos_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      steps_q <= steps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mayor_q <= mayor_d;
      menor_q <= menor_d;
      igual_q <= igual_d;
      pasos_q <= pasos_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= bus.wordA;
      b_q <= bus.wordB;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.mayor = mayor_q;
  assign bus.menor = menor_q;
  assign bus.igual = igual_q;
  assign bus.pasos = pasos_q;
endmodule

// File: tb/tb_control_recorrido.sv
// Directed bench for control_recorrido with N=8, K=4. Inputs are driven 1ns
// after each rising edge; outputs are sampled at the same point.
module tb_control_recorrido;
  localparam int N = 8;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  control_recorrido_if #(.N(N), .K(K)) bus ();

  control_recorrido #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic b, input logic d,
                           input logic my, input logic mn, input logic ig, input int p);
    check_out({tag, ".busy"},  32'(bus.busy),  32'(b));
    check_out({tag, ".done"},  32'(bus.done),  32'(d));
    check_out({tag, ".mayor"}, 32'(bus.mayor), 32'(my));
    check_out({tag, ".menor"}, 32'(bus.menor), 32'(mn));
    check_out({tag, ".igual"}, 32'(bus.igual), 32'(ig));
    check_out({tag, ".pasos"}, 32'(bus.pasos), 32'(p));
  endtask

  // Full compare: start at E0, m SCAN edges, DONE visible after Em, IDLE after E(m+1).
  // hold_start keeps start high through SCAN and DONE; flip_a changes wordA mid-scan.
  task automatic do_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int m, input logic my, input logic mn, input logic ig,
                        input bit hold_start, input bit flip_a);
    bus.wordA = a;
    bus.wordB = b;
    bus.start = 1'b1;
    tick();
    if (!hold_start) bus.start = 1'b0;
    check_out({tag, ".e0.busy"}, 32'(bus.busy), 32'd1);
    check_out({tag, ".e0.done"}, 32'(bus.done), 32'd0);
    for (int i = 1; i <= m; i++) begin
      if (flip_a) bus.wordA = 32'hFFFF_FFFF;
      tick();
      check_out({tag, ".scan.busy"}, 32'(bus.busy), 32'd1);
      check_out({tag, ".scan.done"}, 32'(bus.done), 32'(i == m));
    end
    check_all({tag, ".res"}, 1'b1, 1'b1, my, mn, ig, m);
    tick();
    check_out({tag, ".end.busy"}, 32'(bus.busy), 32'd0);
    check_out({tag, ".end.done"}, 32'(bus.done), 32'd0);
    bus.start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    bus.wordA = $urandom;
    bus.wordB = $urandom;
    #2;
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("reset.hold.busy", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Equal operands walk all four slices.
    do_cmp("equal", 32'h1234_5678, 32'h1234_5678, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // MSB slice decides immediately.
    do_cmp("msb",   32'h8000_0000, 32'h7FFF_FFFF, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Only the LSB slice differs.
    do_cmp("lsb",   32'h0000_0000, 32'h0000_0001, 4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Third slice differs; wordA rewritten during SCAN must not matter.
    do_cmp("mid",   32'h1234_0000, 32'h1234_FF00, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    // start held high through SCAN and DONE, then back-to-back with the next one.
    do_cmp("hold",  32'h0000_0100, 32'h0000_00FF, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_cmp("b2b",   32'hFF00_0000, 32'h0100_0000, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_out("b2b.quiet.busy", 32'(bus.busy), 32'd0);

    // Abort mid-scan: results from previous equal compare must hold.
    do_cmp("pre",   32'h1234_5678, 32'h1234_5678, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.wordA = 32'hAAAA_AAAA;
    bus.wordB = 32'hAAAA_AAAA;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_out("abort.e2.busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_all("abort.e3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("abort.nodone", 32'(bus.done), 32'd0);
    end

    // Async reset mid-scan clears everything at once.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_all("rstmid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Abort beats a compare that would finish on the same edge.
    bus.wordA = 32'h8000_0000;
    bus.wordB = 32'h0000_0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_all("abortprio", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick();
    check_out("abortprio.nodone", 32'(bus.done), 32'd0);

    // Abort while idle is harmless; a normal compare follows.
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    do_cmp("after", 32'h0012_0000, 32'h0011_FFFF, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
